// File: rtl/vga_ctrl.sv
// 640x480@60 raster timing generator: counters, look-ahead pixel request and a
// registered sync/blank/RGB stage for an ADV7123-style DAC.
module vga_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [23:0] pix_rgb,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        line_start,
  output logic [7:0]  frame_cnt,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT0     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT1     = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] V_ACT0     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT1     = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0] H_REQ0     = H_ACT0 - 10'd1;
  localparam logic [9:0] H_REQ1     = H_ACT1 - 10'd1;

  function automatic logic in_win(input logic [9:0] c, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic       run_p0;
  logic [9:0] h_cnt_p0;
  logic [9:0] v_cnt_p0;
  logic       hs_int;
  logic       vs_int;
  logic       de_int;
  logic       v_act;

  // Stage p0: raster counters; run_p0 holds them at 0,0 for the first edge after reset
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      run_p0    <= 1'b0;
      h_cnt_p0  <= '0;
      v_cnt_p0  <= '0;
      frame_cnt <= '0;
    end else begin
      run_p0 <= 1'b1;
      if (run_p0) begin
        if (h_cnt_p0 == H_LAST) begin
          h_cnt_p0 <= '0;
          if (v_cnt_p0 == V_LAST) begin
            v_cnt_p0  <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            v_cnt_p0 <= v_cnt_p0 + 10'd1;
          end
        end else begin
          h_cnt_p0 <= h_cnt_p0 + 10'd1;
        end
      end
    end
  end

  always_comb begin
    hs_int      = (h_cnt_p0 < H_SYNC_END);
    vs_int      = (v_cnt_p0 < V_SYNC_END);
    v_act       = in_win(v_cnt_p0, V_ACT0, V_ACT1);
    de_int      = v_act && in_win(h_cnt_p0, H_ACT0, H_ACT1);
    pix_req     = v_act && in_win(h_cnt_p0, H_REQ0, H_REQ1);
    pix_x       = pix_req ? (h_cnt_p0 - H_REQ0) : 10'h3FF;
    pix_y       = pix_req ? (v_cnt_p0 - V_ACT0) : 10'h3FF;
    line_start  = (h_cnt_p0 == 10'd0);
    frame_start = (h_cnt_p0 == 10'd0) && (v_cnt_p0 == 10'd0);
  end

  // Stage p1: DAC-facing register, sync/blank/colour kept mutually aligned
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs                <= ~hs_int;
      vga_vs                <= ~vs_int;
      vga_blank_n           <= de_int;
      {vga_r, vga_g, vga_b} <= de_int ? pix_rgb : 24'h0;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench: full-size instance for line/request timing, a shrunken-raster
// instance for frame-level behaviour (frame counter wrap, mid-frame reset).
module tb_vga_ctrl;

  typedef struct {
    int          pos;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst1 = 1'b1;
  logic [23:0] rgb0 = '0;
  logic [23:0] rgb1 = '0;

  logic       d0_req, d0_fs, d0_ls, d0_hs, d0_vs, d0_bl, d0_sn;
  logic [9:0] d0_x, d0_y;
  logic [7:0] d0_fc, d0_r, d0_g, d0_b;
  logic       s1_req, s1_fs, s1_ls, s1_hs, s1_vs, s1_bl, s1_sn;
  logic [9:0] s1_x, s1_y;
  logic [7:0] s1_fc, s1_r, s1_g, s1_b;

  vga_ctrl dut0 (
    .vga_clk(clk), .sys_rst(rst0), .pix_rgb(rgb0),
    .pix_req(d0_req), .pix_x(d0_x), .pix_y(d0_y),
    .frame_start(d0_fs), .line_start(d0_ls), .frame_cnt(d0_fc),
    .vga_hs(d0_hs), .vga_vs(d0_vs), .vga_blank_n(d0_bl), .vga_sync_n(d0_sn),
    .vga_r(d0_r), .vga_g(d0_g), .vga_b(d0_b)
  );

  // 16x8 raster: active h [6,14), request h [5,13), active v [3,7)
  vga_ctrl #(
    .H_SYNC(4), .H_BACK(2), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_VALID(4), .V_FRONT(1)
  ) dut1 (
    .vga_clk(clk), .sys_rst(rst1), .pix_rgb(rgb1),
    .pix_req(s1_req), .pix_x(s1_x), .pix_y(s1_y),
    .frame_start(s1_fs), .line_start(s1_ls), .frame_cnt(s1_fc),
    .vga_hs(s1_hs), .vga_vs(s1_vs), .vga_blank_n(s1_bl), .vga_sync_n(s1_sn),
    .vga_r(s1_r), .vga_g(s1_g), .vga_b(s1_b)
  );

  always #5 clk = ~clk;

  // Picture-stage ROM stand-in with one clock of latency
  always @(posedge clk) begin
    rgb0 <= {d0_x[7:0], d0_y[7:0], 8'hA5};
    rgb1 <= {s1_x[7:0], s1_y[7:0], 8'hA5};
  end

  int tests = 0;
  int fails = 0;
  int pos = -1;
  int phase = 0;
  int bad_blank = 0, bad_sync = 0;
  int hs_low = 0, ls_bad = 0, ls_seen = 0, last_ls = -1;
  int vs_low = 0, act_lines = 0, fs_bad = 0, fs_seen = 0, last_fs = -1;
  logic prev_bl = 1'b0;

  vec_t dtab[$];
  vec_t stab[$];
  vec_t rtab[$];

  function automatic logic [63:0] pack(input logic hs, input logic vs, input logic bl,
                                       input logic rq, input logic ls, input logic fs,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic [23:0] rgb, input logic [7:0] fc);
    return {6'b0, hs, vs, bl, rq, ls, fs, x, y, rgb, fc};
  endfunction

  function automatic logic [63:0] obs(input bit sel);
    if (sel)
      return pack(s1_hs, s1_vs, s1_bl, s1_req, s1_ls, s1_fs, s1_x, s1_y,
                  {s1_r, s1_g, s1_b}, s1_fc);
    return pack(d0_hs, d0_vs, d0_bl, d0_req, d0_ls, d0_fs, d0_x, d0_y,
                {d0_r, d0_g, d0_b}, d0_fc);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock; pos counts edges since reset release (0 = the hold edge)
  task automatic tick();
    @(negedge clk);
    pos++;
    if (!d0_bl && ({d0_r, d0_g, d0_b} != '0)) bad_blank++;
    if (!s1_bl && ({s1_r, s1_g, s1_b} != '0)) bad_blank++;
    if (d0_sn !== 1'b0 || s1_sn !== 1'b0) bad_sync++;
    if (phase == 0) begin
      if (pos >= 1 && pos <= 800 && !d0_hs) hs_low++;
      if (d0_ls) begin
        if (last_ls >= 0 && (pos - last_ls) != 800) ls_bad++;
        last_ls = pos;
        ls_seen++;
      end
    end else if (phase == 1) begin
      if (pos >= 1 && pos <= 128) begin
        if (!s1_vs) vs_low++;
        if (s1_bl && !prev_bl) act_lines++;
      end
      prev_bl = s1_bl;
      if (s1_fs) begin
        if (last_fs >= 0 && (pos - last_fs) != 128) fs_bad++;
        last_fs = pos;
        fs_seen++;
      end
    end
  endtask

  task automatic run_tab(input vec_t t[$], input bit sel, input string tag);
    for (int i = 0; i < t.size(); i++) begin
      while (pos < t[i].pos) tick();
      check($sformatf("%s[%0d] pos=%0d", tag, i, t[i].pos), obs(sel), t[i].exp);
    end
  endtask

  initial begin
    //                          hs  vs  bl  rq  ls  fs  x        y        rgb          fc
    dtab.push_back('{0,     pack(0,  0,  0,  0,  1,  1,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{1,     pack(0,  0,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{96,    pack(0,  0,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{97,    pack(1,  0,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{800,   pack(1,  0,  0,  0,  1,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{1601,  pack(0,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{28142, pack(1,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{28143, pack(1,  1,  0,  1,  0,  0,  10'd0,   10'd0,   24'h0,       8'd0)});
    dtab.push_back('{28145, pack(1,  1,  1,  1,  0,  0,  10'd2,   10'd0,   24'h0000A5,  8'd0)});
    dtab.push_back('{28146, pack(1,  1,  1,  1,  0,  0,  10'd3,   10'd0,   24'h0100A5,  8'd0)});
    dtab.push_back('{28782, pack(1,  1,  1,  1,  0,  0,  10'd639, 10'd0,   24'h7D00A5,  8'd0)});
    dtab.push_back('{28783, pack(1,  1,  1,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h7E00A5,  8'd0)});
    dtab.push_back('{28784, pack(1,  1,  1,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h7F00A5,  8'd0)});
    dtab.push_back('{28785, pack(1,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    dtab.push_back('{28945, pack(1,  1,  1,  1,  0,  0,  10'd2,   10'd1,   24'h0001A5,  8'd0)});

    stab.push_back('{0,     pack(0,  0,  0,  0,  1,  1,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    stab.push_back('{53,    pack(1,  1,  0,  1,  0,  0,  10'd0,   10'd0,   24'h0,       8'd0)});
    stab.push_back('{55,    pack(1,  1,  1,  1,  0,  0,  10'd2,   10'd0,   24'h0000A5,  8'd0)});
    stab.push_back('{110,   pack(1,  1,  1,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0703A5,  8'd0)});
    stab.push_back('{111,   pack(1,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    stab.push_back('{127,   pack(1,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    stab.push_back('{128,   pack(1,  1,  0,  0,  1,  1,  10'h3FF, 10'h3FF, 24'h0,       8'd1)});
    stab.push_back('{129,   pack(0,  0,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd1)});
    stab.push_back('{32640, pack(1,  1,  0,  0,  1,  1,  10'h3FF, 10'h3FF, 24'h0,       8'd255)});
    stab.push_back('{32767, pack(1,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd255)});
    stab.push_back('{32768, pack(1,  1,  0,  0,  1,  1,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    stab.push_back('{33225, pack(1,  1,  1,  1,  0,  0,  10'd4,   10'd1,   24'h0201A5,  8'd3)});

    rtab.push_back('{0,     pack(0,  0,  0,  0,  1,  1,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    rtab.push_back('{52,    pack(0,  1,  0,  0,  0,  0,  10'h3FF, 10'h3FF, 24'h0,       8'd0)});
    rtab.push_back('{53,    pack(1,  1,  0,  1,  0,  0,  10'd0,   10'd0,   24'h0,       8'd0)});

    // Reset state of both instances
    #12;
    check("reset_d0", obs(1'b0), pack(1, 1, 0, 0, 1, 1, 10'h3FF, 10'h3FF, 24'h0, 8'd0));
    check("reset_s1", obs(1'b1), pack(1, 1, 0, 0, 1, 1, 10'h3FF, 10'h3FF, 24'h0, 8'd0));
    check("reset_sync_n", {63'b0, d0_sn}, 64'd0);

    phase = 0;
    @(negedge clk);
    rst0 = 1'b0;
    pos = -1;
    run_tab(dtab, 1'b0, "line");
    check_int("hs_low_per_line", hs_low, 96);
    check_int("line_start_period_errs", ls_bad, 0);
    check_int("line_start_count", ls_seen, 37);

    phase = 1;
    @(negedge clk);
    rst1 = 1'b0;
    pos = -1;
    run_tab(stab, 1'b1, "frame");
    check_int("vs_low_per_frame", vs_low, 32);
    check_int("active_lines", act_lines, 4);
    check_int("frame_start_period_errs", fs_bad, 0);
    check_int("frame_start_count", fs_seen, 260);

    // Mid-frame asynchronous reset: clears without a clock edge
    #2 rst1 = 1'b1;
    #1 check("async_clear", obs(1'b1), pack(1, 1, 0, 0, 1, 1, 10'h3FF, 10'h3FF, 24'h0, 8'd0));
    phase = 2;
    repeat (3) tick();
    rst1 = 1'b0;
    pos = -1;
    run_tab(rtab, 1'b1, "restart");

    check_int("rgb_zero_when_blank_errs", bad_blank, 0);
    check_int("sync_n_nonzero_errs", bad_sync, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

Raster timing generator for the 640x480@60 Hz VGA output, clocked by the 25.175 MHz pixel clock. It drives `pix_x`/`pix_y` one clock ahead of the active pixel so the picture stage's 1-cycle ROM can return data in time. It samples the returned 24-bit colour and emits registered sync, blank and RGB signals to the DAC (ADV7123-style). It also provides frame/line strobes and a frame counter for animation logic.

## Interface
- `H_SYNC`, 96: hsync pulse width, clocks
- `H_BACK`, 48: horizontal back porch
- `H_VALID`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch (H_TOTAL = 800)
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BACK`, 33: vertical back porch
- `V_VALID`, 480: active lines
- `V_FRONT`, 10: vertical front porch (V_TOTAL = 525)
- `vga_clk`  in  1  pixel clock; all state on rising edge
- `sys_rst`  in  1  asynchronous, active-high reset
- `pix_rgb`  in  24  colour from picture stage, {R,G,B}; valid the cycle after a request
- `pix_req`  out  1  pixel request; high one clock before each active pixel
- `pix_x`  out  10  requested column 0..639; 10'h3FF when `pix_req`=0
- `pix_y`  out  10  requested row 0..479; 10'h3FF when `pix_req`=0
- `frame_start`  out  1  one-cycle strobe at h_cnt=0, v_cnt=0
- `line_start`  out  1  one-cycle strobe at h_cnt=0
- `frame_cnt`  out  8  completed-frame count, wraps 255->0
- `vga_hs`, `vga_vs`  out  1  active-low syncs, registered
- `vga_blank_n`  out  1  high during active video, registered
- `vga_sync_n`  out  1  tied 0 (no sync-on-green)
- `vga_r`, `vga_g`, `vga_b`  out  8  registered colour; 0 outside active video

## Operation
- `h_cnt` is 10 bits, 0..H_TOTAL-1. It wraps to 0 after 799. At wrap, `v_cnt` (10 bits, 0..V_TOTAL-1) increments. `v_cnt` wraps to 0 after 524.
- The count origin is the start of the sync pulse: hs_int = (h_cnt < H_SYNC); vs_int = (v_cnt < V_SYNC).
- Active region is h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) = [144,784) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID) = [35,515). de_int is high in this region.
- Request window is the same region shifted one clock earlier horizontally: h_cnt in [143,783), same rows.
- Inside the request window, `pix_x` = h_cnt-143 and `pix_y` = v_cnt-35.
- `pix_req`, `pix_x`, `pix_y`, `line_start` and `frame_start` are combinational decodes of the counters. They are glitch-tolerant because consumers sample them on `vga_clk`.
- Output register, on each edge:
  - `vga_hs` <= ~hs_int
  - `vga_vs` <= ~vs_int
  - `vga_blank_n` <= de_int
  - `{vga_r,vga_g,vga_b}` <= de_int ? `pix_rgb` : 24'h0
- `frame_cnt` increments on the edge where h_cnt=799 and v_cnt=524.
- `sys_rst` asserted at any time, including mid-line or mid-frame:
  - counters and `frame_cnt` go to 0 and the output register clears immediately.
  - After release, counting restarts from 0,0. There is no partial-frame recovery.

## Timing
- Reset values:
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, `vga_sync_n`=0, `vga_r/g/b`=0, `frame_cnt`=0.
  - Counters are 0, so `frame_start`=1 and `line_start`=1 during reset. `pix_req`=0, `pix_x`=`pix_y`=10'h3FF.
- First edge after reset release: `vga_hs` and `vga_vs` go low. The counters stay at 0,0 on that edge, then advance.
- Request-to-pixel latency:
  - `pix_x`=N is presented at cycle t.
  - `pix_rgb` for N is sampled at t+1.
  - It appears on `vga_r/g/b` after the t+1 edge, with `vga_blank_n` high in the same cycle.
- All DAC-facing outputs carry one register stage of delay relative to the counters. Sync, blank and colour stay mutually aligned.
- Line period is 800 clocks. Frame period is 420000 clocks.
- `vga_hs` is low for exactly 96 clocks per line. `vga_vs` is low for exactly 1600 clocks per frame.

## Test plan
- Reset then run one line: `vga_hs` low for 96 clocks, `line_start` period 800, `vga_sync_n` constant 0.
- Request alignment:
  - `pix_req` first rises at h_cnt=143 on v_cnt=35, with `pix_x`=0 and `pix_y`=0.
  - `pix_x`=639 occurs at h_cnt=782.
  - At h_cnt=783, `pix_req`=0 and `pix_x`=3FF.
- Drive `pix_rgb` = {pix_x[7:0], pix_y[7:0], 8'hA5}, delayed one clock:
  - first `vga_blank_n`-high cycle shows R=00, G=00, B=A5.
  - the last pixel of row 479 shows R=7F, G=DF, B=A5.
  - R/G/B are 0 whenever `vga_blank_n`=0.
- Full frame: `vga_vs` low for 1600 clocks, exactly 480 lines with active video, `frame_start` period 420000.
- Run 256 frames: `frame_cnt` reaches 255, then wraps to 0 with `frame_start` coincident.
- Assert `sys_rst` for 3 clocks at v_cnt=200, h_cnt=400: outputs clear asynchronously. After release, the next `pix_req` rise occurs exactly 35*800+143 clocks later.
